// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared fetch-stage types, constants and helpers
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_redirect_unit_if.sv
// rtl/fetch_redirect_unit_if.sv - instruction-memory and decode handshake bundle
interface fetch_redirect_unit_if;
  import riscv_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_gnt;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            id_ready;

  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_gnt, imem_rvalid, imem_rdata, id_ready
  );

endinterface

// File: rtl/fetch_redirect_unit_pc_next_sel.sv
// rtl/fetch_redirect_unit_pc_next_sel.sv - redirect decode and next-PC selection
module pc_next_sel
  import riscv_pkg::*;
(
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic            br_true,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] pc_q,
  input  logic            advance,
  output logic            redirect,
  output logic            misalign,
  output logic [XLEN-1:0] pc_next
);

  assign redirect = ex_is_jump | (ex_is_branch & br_true);
  // bit1 is flagged but still followed; bit0 is dropped as JALR does
  assign misalign = redirect & ex_target[1];

  always_comb begin
    pc_next = pc_q;
    if (redirect) begin
      pc_next = word_align(ex_target);
    end else if (advance) begin
      pc_next = pc_q + PC_INCR;
    end
  end

endmodule

// File: rtl/fetch_redirect_unit.sv
// rtl/fetch_redirect_unit.sv - fetch stage: PC, imem requests, redirect squash, output register
module fetch_redirect_unit #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ex_is_branch,
  input  logic                        ex_is_jump,
  input  logic                        br_true,
  input  logic [XLEN-1:0]             ex_target,
  fetch_redirect_unit_if.master       bus,
  output logic                        flush_o,
  output logic                        misalign_o
);
  import riscv_pkg::*;

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [XLEN-1:0] if_pc_q;
  logic [XLEN-1:0] if_instr_q;
  logic            valid_q;
  logic            kill_q;

  logic            redirect;
  logic            misalign;
  logic [XLEN-1:0] pc_next;
  logic            if_valid;
  logic            handshake;
  logic            slot_free;
  logic            advance;

  pc_next_sel u_pc_next_sel (
    .ex_is_branch (ex_is_branch),
    .ex_is_jump   (ex_is_jump),
    .br_true      (br_true),
    .ex_target    (ex_target),
    .pc_q         (pc_q),
    .advance      (advance),
    .redirect     (redirect),
    .misalign     (misalign),
    .pc_next      (pc_next)
  );

  assign if_valid  = valid_q & ~redirect;
  assign handshake = if_valid & bus.id_ready;
  // only request when the output register will be empty by the time data returns
  assign slot_free = ~valid_q | handshake;
  assign advance   = bus.imem_req & bus.imem_gnt;

  assign bus.imem_req  = (state == REQ) & ~redirect & slot_free;
  assign bus.imem_addr = (state == REQ) ? pc_q : '0;
  assign bus.if_valid  = if_valid;
  assign bus.if_pc     = if_pc_q;
  assign bus.if_instr  = if_instr_q;
  assign flush_o       = redirect & rst_n;
  assign misalign_o    = misalign & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      valid_q    <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      pc_q <= pc_next;
      if (redirect || handshake) begin
        valid_q <= 1'b0;
      end
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (advance) begin
            fetch_pc_q <= pc_q;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            if (!kill_q && !redirect) begin
              valid_q    <= 1'b1;
              if_instr_q <= bus.imem_rdata;
              if_pc_q    <= fetch_pc_q;
            end
            kill_q <= 1'b0;
            state  <= REQ;
          end else if (redirect) begin
            // the in-flight response belongs to the wrong path
            kill_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
